lease_rr_arbiter: RTL
=====================

Name: lease_rr_arbiter

Overview:
- Time-multiplexed lease engine: grants a bounded-duration lease to one of NCH data channels in round-robin order.
- During a lease it accumulates an increment per cycle while the channel's data bit is high, switching between two increment phases whenever the bit is low.
- At lease expiry or on revoke, it publishes the accumulator to that channel's output register.
- Parametrised successor of the two-channel lease block, adding N channels, a channel enable mask, early revoke, configurable increments and a per-channel valid strobe.

Parameters:
- NCH, 4: number of channels (>=2).
- W, 8: accumulator/output width per channel.
- TW, 8: lease timer width.
- INC_A, 1: increment applied in PHASE_A.
- INC_B, 2: increment applied in PHASE_B.
- CW, $clog2(NCH): channel index width (derived).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- timer  input  TW  lease length request; nonzero starts a lease when IDLE.
- ch_en  input  NCH  channel enable mask; sampled only at grant.
- data  input  NCH  per-channel activity bit.
- revoke  input  1  terminates the current lease early.
- out  output  NCH*W  published result registers; channel i at bits [i*W +: W].
- out_valid  output  NCH  one-cycle strobe, bit i high the cycle after channel i's out is written.
- busy  output  1  high while in PHASE_A/PHASE_B.
- cur_ch  output  CW  channel holding (or last holding) the lease.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out, out_valid, busy, cur_ch, acc, local_timer and rr pointer all 0.
- States are IDLE, PHASE_A and PHASE_B. busy is registered and equals (state != IDLE).

IDLE:
- Grant occurs when timer != 0 and ch_en != 0.
- The granted channel is the lowest-index enabled channel at or after the rr pointer, searching circularly.
- On grant: cur_ch <= chosen; ptr <= (chosen+1) mod NCH; local_timer <= timer; acc <= 0; state <= PHASE_A.
- If timer == 0 or ch_en == 0, the block stays IDLE with no state change.

PHASE_A / PHASE_B (ch = cur_ch), in priority order:
1. revoke=1: out[ch] <= acc; out_valid[ch] pulses; state <= IDLE. No accumulate or decrement on that edge.
2. local_timer == 0: out[ch] <= acc; out_valid[ch] pulses; state <= IDLE.
3. Otherwise local_timer <= local_timer-1, and:
   - if data[ch] == 0: toggle phase (A<->B), acc unchanged;
   - else: acc <= acc + INC_A (in PHASE_A) or acc + INC_B (in PHASE_B).

Timing and side rules:
- Timing: grant at edge k with timer=T. Edges k+1..k+T decrement/accumulate. Publish at edge k+T+1. out_valid high for cycle k+T+1..k+T+2. Earliest next grant is at edge k+T+2.
- Arithmetic: acc wraps modulo 2^W, with no saturation and no overflow flag. timer is zero-extended internally.
- out_valid is registered, at most one bit set, and cleared on the next edge.
- out[j] for non-leased channels holds its value; only the leased channel's register is written.
- data bits of non-leased channels are ignored. ch_en/timer changes mid-lease are ignored. revoke in IDLE is ignored.
- Reset mid-lease: immediate return to reset values. The partial acc is discarded and no out_valid is produced.

Test Plan:
- Basic lease: ch_en=4'b1111, timer=3 for one cycle, data=all 1s -> cur_ch=0, busy for 4 cycles, out[0]=3, out_valid=4'b0001 for exactly one cycle, other outs 0.
- Phase toggle: timer=5, ch0 data sequence 1,0,1,1,0 -> acc steps 1,(toggle to B),3,5,(toggle to A) -> out[0]=5.
- Round-robin with mask: ch_en=4'b1010, timer=1 held continuously -> grants cur_ch=1,3,1,3. out[0] and out[2] never written. Each lease publishes 1 when data high.
- Revoke: timer=10, data=1, revoke asserted on the 4th cycle after grant -> out[ch]=3 published that edge, busy drops, timer remainder discarded.
- Wrap-around (W=4 instance): timer=20, data=1 -> out[ch]=20 mod 16 = 4.
- Reset mid-lease: reset driven low 2 cycles into a timer=8 lease -> all outputs 0 immediately, no out_valid. After release, the next grant goes to channel 0.

Source files
------------

// File: rtl/lease_rr_arbiter.sv
// lease_rr_arbiter: round-robin lease engine accumulating per-channel activity and publishing it at lease end
module lease_rr_arbiter #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int TW    = 8,
  parameter int INC_A = 1,
  parameter int INC_B = 2,
  parameter int CW    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TW-1:0]      timer,
  input  logic [NCH-1:0]     ch_en,
  input  logic [NCH-1:0]     data,
  input  logic               revoke,
  output logic [NCH*W-1:0]   out,
  output logic [NCH-1:0]     out_valid,
  output logic               busy,
  output logic [CW-1:0]      cur_ch
);
  typedef enum logic [1:0] {IDLE, PHASE_A, PHASE_B} state_t;
  state_t          state;
  logic [CW-1:0]   ptr;
  logic [TW-1:0]   local_timer;
  logic [W-1:0]    acc;
  logic            found;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   pick_next;
  int              c;
  // circular search for the first enabled channel at or after the rr pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    c     = 0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!found && ch_en[c]) begin
        found = 1'b1;
        pick  = CW'(c);
      end
    end
    pick_next = (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
  end
  // lease FSM: grant, accumulate with phase toggling, publish on expiry or revoke
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      local_timer <= '0;
      acc         <= '0;
      out         <= '0;
      out_valid   <= '0;
      busy        <= 1'b0;
      cur_ch      <= '0;
    end else begin
      out_valid <= '0;
      if (state == IDLE) begin
        if (timer != '0 && found) begin
          cur_ch      <= pick;
          ptr         <= pick_next;
          local_timer <= timer;
          acc         <= '0;
          state       <= PHASE_A;
          busy        <= 1'b1;
        end
      end else if (revoke || local_timer == '0) begin
        out[int'(cur_ch)*W +: W] <= acc;
        out_valid[cur_ch]        <= 1'b1;
        state                    <= IDLE;
        busy                     <= 1'b0;
      end else begin
        local_timer <= local_timer - 1'b1;
        if (!data[cur_ch]) state <= (state == PHASE_A) ? PHASE_B : PHASE_A;
        else acc <= acc + ((state == PHASE_A) ? W'(INC_A) : W'(INC_B));
      end
    end
  end
endmodule
